// File: rtl/operand_bypass_ctrl.sv
// EX-stage operand bypass selection, load-use / long-latency hazard detection and a countdown scoreboard.
// Optional performance counters are compiled in with `define BYPASS_PERF_CNT_EN.
module operand_bypass_ctrl #(
  parameter int NUM_SRC = 3,
  parameter int NUM_FWD = 2,
  parameter int ADDR_W  = 5,
  parameter int NUM_SB  = 4,
  parameter int MAX_LAT = 15,
  localparam int CNT_W  = $clog2(MAX_LAT + 1),
  localparam int SEL_W  = $clog2(NUM_FWD + 1),
  localparam int SBC_W  = $clog2(NUM_SB + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ex_valid,
  input  logic [NUM_SRC*ADDR_W-1:0] ex_src_addr,
  input  logic [NUM_SRC-1:0]        ex_src_used,
  input  logic [NUM_FWD-1:0]        fwd_reg_write,
  input  logic [NUM_FWD*ADDR_W-1:0] fwd_rd_addr,
  input  logic [NUM_FWD-1:0]        fwd_data_ready,
  input  logic                      lat_issue,
  input  logic [ADDR_W-1:0]         lat_rd_addr,
  input  logic [CNT_W-1:0]          lat_cycles,
  input  logic                      flush,
  output logic [NUM_SRC*SEL_W-1:0]  fwd_sel,
  output logic                      stall,
  output logic                      sb_full,
  output logic [SBC_W-1:0]          sb_count
`ifdef BYPASS_PERF_CNT_EN
  ,
  output logic [31:0]               perf_stall_load,
  output logic [31:0]               perf_stall_sb,
  output logic [31:0]               perf_fwd_hits
`endif
);

  logic [NUM_SB-1:0]  sb_valid;
  logic [ADDR_W-1:0]  sb_rd [NUM_SB];
  logic [NUM_SB-1:0]  alloc_grant;
  logic               alloc_seen;
  logic               alloc_en;
  logic [CNT_W-1:0]   alloc_cnt;
  logic [NUM_SRC-1:0] load_haz;
  logic [NUM_SRC-1:0] sb_haz;
  logic               waw_hit;
  logic               h_load;
  logic               h_sb;
  logic               h_issue;

  // Scoreboard: one entry per in-flight long-latency write, counting down to register-file visibility.
  for (genvar gi = 0; gi < NUM_SB; gi++) begin : g_sb
    logic              valid_reg;
    logic [ADDR_W-1:0] rd_reg;
    logic [CNT_W-1:0]  cnt_reg;

    always_ff @(posedge clk) begin
      if (rst) begin
        valid_reg <= 1'b0;
        rd_reg    <= '0;
        cnt_reg   <= '0;
      end else if (flush) begin
        valid_reg <= 1'b0;
      end else if (valid_reg) begin
        cnt_reg <= cnt_reg - 1'b1;
        if (cnt_reg == CNT_W'(1)) valid_reg <= 1'b0;
      end else if (alloc_en && alloc_grant[gi]) begin
        valid_reg <= 1'b1;
        rd_reg    <= lat_rd_addr;
        cnt_reg   <= alloc_cnt;
      end
    end

    assign sb_valid[gi] = valid_reg;
    assign sb_rd[gi]    = rd_reg;
  end

  // Grant is based on current valid bits, so a slot retiring this cycle is not reused until the next.
  always_comb begin
    alloc_grant = '0;
    alloc_seen  = 1'b0;
    for (int e = 0; e < NUM_SB; e++) begin
      if (!sb_valid[e] && !alloc_seen) begin
        alloc_grant[e] = 1'b1;
        alloc_seen     = 1'b1;
      end
    end
  end

  always_comb begin
    sb_count = '0;
    for (int e = 0; e < NUM_SB; e++) sb_count = sb_count + SBC_W'(sb_valid[e]);
  end

  assign sb_full = (sb_count == SBC_W'(NUM_SB));

  always_comb begin
    waw_hit = 1'b0;
    for (int e = 0; e < NUM_SB; e++)
      if (sb_valid[e] && (sb_rd[e] == lat_rd_addr)) waw_hit = 1'b1;
  end

  for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
    logic [ADDR_W-1:0] addr;
    logic              live;
    logic [SEL_W-1:0]  sel;
    logic              ready;
    logic              sb_hit;

    assign addr = ex_src_addr[gi*ADDR_W +: ADDR_W];
    assign live = ex_src_used[gi] && (addr != '0);

    // Scan oldest to youngest so the youngest matching stage overrides.
    always_comb begin
      sel   = '0;
      ready = 1'b1;
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (fwd_reg_write[k] && (fwd_rd_addr[k*ADDR_W +: ADDR_W] == addr)) begin
          sel   = SEL_W'(k + 1);
          ready = fwd_data_ready[k];
        end
      end
    end

    always_comb begin
      sb_hit = 1'b0;
      for (int e = 0; e < NUM_SB; e++)
        if (sb_valid[e] && (sb_rd[e] == addr)) sb_hit = 1'b1;
    end

    assign load_haz[gi] = live && (sel != '0) && !ready;
    assign sb_haz[gi]   = live && sb_hit;
    assign fwd_sel[gi*SEL_W +: SEL_W] = (live && !rst) ? sel : '0;
  end

  assign h_load    = |load_haz;
  assign h_sb      = |sb_haz;
  assign h_issue   = lat_issue && (sb_full || waw_hit);
  assign stall     = !rst && ex_valid && (h_load || h_sb || h_issue);
  assign alloc_en  = ex_valid && lat_issue && !stall && !flush && (lat_rd_addr != '0);
  assign alloc_cnt = (lat_cycles == '0) ? CNT_W'(1) : lat_cycles;

`ifdef BYPASS_PERF_CNT_EN
  logic [31:0] hit_count;

  always_comb begin
    hit_count = '0;
    for (int i = 0; i < NUM_SRC; i++)
      hit_count = hit_count + 32'(fwd_sel[i*SEL_W +: SEL_W] != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_load <= '0;
      perf_stall_sb   <= '0;
      perf_fwd_hits   <= '0;
    end else begin
      if (stall && h_load) perf_stall_load <= perf_stall_load + 32'd1;
      if (stall && h_sb)   perf_stall_sb   <= perf_stall_sb + 32'd1;
      if (ex_valid && !stall) perf_fwd_hits <= perf_fwd_hits + hit_count;
    end
  end
`endif

endmodule

// File: tb/tb_operand_bypass_ctrl.sv
// Directed bench for operand_bypass_ctrl: forwarding priority, load-use, scoreboard countdown/full/WAW, flush and reset.
module tb_operand_bypass_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [14:0] ex_src_addr;
  logic [2:0]  ex_src_used;
  logic [1:0]  fwd_reg_write;
  logic [9:0]  fwd_rd_addr;
  logic [1:0]  fwd_data_ready;
  logic        lat_issue;
  logic [4:0]  lat_rd_addr;
  logic [3:0]  lat_cycles;
  logic        flush;
  logic [5:0]  fwd_sel;
  logic        stall;
  logic        sb_full;
  logic [2:0]  sb_count;
`ifdef BYPASS_PERF_CNT_EN
  logic [31:0] perf_stall_load;
  logic [31:0] perf_stall_sb;
  logic [31:0] perf_fwd_hits;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  operand_bypass_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .ex_valid       (ex_valid),
    .ex_src_addr    (ex_src_addr),
    .ex_src_used    (ex_src_used),
    .fwd_reg_write  (fwd_reg_write),
    .fwd_rd_addr    (fwd_rd_addr),
    .fwd_data_ready (fwd_data_ready),
    .lat_issue      (lat_issue),
    .lat_rd_addr    (lat_rd_addr),
    .lat_cycles     (lat_cycles),
    .flush          (flush),
    .fwd_sel        (fwd_sel),
    .stall          (stall),
    .sb_full        (sb_full),
    .sb_count       (sb_count)
`ifdef BYPASS_PERF_CNT_EN
    ,
    .perf_stall_load(perf_stall_load),
    .perf_stall_sb  (perf_stall_sb),
    .perf_fwd_hits  (perf_fwd_hits)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic idle();
    ex_valid       = 1'b0;
    ex_src_addr    = '0;
    ex_src_used    = '0;
    fwd_reg_write  = '0;
    fwd_rd_addr    = '0;
    fwd_data_ready = 2'b11;
    lat_issue      = 1'b0;
    lat_rd_addr    = '0;
    lat_cycles     = '0;
    flush          = 1'b0;
  endtask

  task automatic set_src(input int i, input logic [4:0] a);
    ex_src_addr[i*5 +: 5] = a;
    ex_src_used[i]        = 1'b1;
  endtask

  task automatic set_fwd(input int k, input logic we, input logic [4:0] rd, input logic rdy);
    fwd_reg_write[k]      = we;
    fwd_rd_addr[k*5 +: 5] = rd;
    fwd_data_ready[k]     = rdy;
  endtask

  task automatic issue(input logic [4:0] rd, input logic [3:0] lat);
    ex_valid    = 1'b1;
    lat_issue   = 1'b1;
    lat_rd_addr = rd;
    lat_cycles  = lat;
  endtask

  function automatic logic [31:0] sel_of(input int i);
    return 32'(fwd_sel[i*2 +: 2]);
  endfunction

  initial begin
    // Reset with a would-be load-use hazard present: outputs forced low
    idle();
    rst = 1'b1;
    ex_valid = 1'b1;
    set_src(0, 5'd5);
    set_fwd(0, 1'b1, 5'd5, 1'b0);
    #1;
    check("rst_fwd_sel", 32'(fwd_sel), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    idle();
    #1;
    check("post_rst_count", 32'(sb_count), 32'd0);
    check("post_rst_full", 32'(sb_full), 32'd0);
    check("post_rst_stall", 32'(stall), 32'd0);

    // Forwarding priority
    @(negedge clk); idle();
    ex_valid = 1'b1; set_src(0, 5'd5);
    set_fwd(0, 1'b1, 5'd5, 1'b1); set_fwd(1, 1'b1, 5'd5, 1'b1);
    #1;
    check("prio_young_sel", sel_of(0), 32'd1);
    check("prio_young_stall", 32'(stall), 32'd0);
    @(negedge clk);
    set_fwd(0, 1'b0, 5'd5, 1'b1);
    #1;
    check("prio_old_sel", sel_of(0), 32'd2);
    @(negedge clk);
    set_fwd(0, 1'b1, 5'd5, 1'b1); set_fwd(1, 1'b1, 5'd5, 1'b0);
    #1;
    check("prio_old_notready_sel", sel_of(0), 32'd1);
    check("prio_old_notready_stall", 32'(stall), 32'd0);

    // x0 and unused operands
    @(negedge clk); idle();
    ex_valid = 1'b1; set_src(1, 5'd0);
    set_fwd(0, 1'b1, 5'd0, 1'b0);
    #1;
    check("x0_sel", 32'(fwd_sel), 32'd0);
    check("x0_stall", 32'(stall), 32'd0);
    @(negedge clk); idle();
    ex_valid = 1'b1; ex_src_addr[14:10] = 5'd7;
    set_fwd(0, 1'b1, 5'd7, 1'b0);
    #1;
    check("unused_sel", 32'(fwd_sel), 32'd0);
    check("unused_stall", 32'(stall), 32'd0);

    // Load-use
    @(negedge clk); idle();
    ex_valid = 1'b1; set_src(0, 5'd3);
    set_fwd(0, 1'b1, 5'd3, 1'b0);
    #1;
    check("load_use_stall", 32'(stall), 32'd1);
    check("load_use_sel", sel_of(0), 32'd1);
    @(negedge clk);
    fwd_data_ready[0] = 1'b1;
    #1;
    check("load_done_stall", 32'(stall), 32'd0);
    check("load_done_sel", sel_of(0), 32'd1);
    @(negedge clk); idle();
    set_src(0, 5'd4); set_fwd(1, 1'b1, 5'd4, 1'b0);
    #1;
    check("load_novalid_stall", 32'(stall), 32'd0);
    ex_valid = 1'b1;
    #1;
    check("load_wb_stall", 32'(stall), 32'd1);
    check("load_wb_sel", sel_of(0), 32'd2);

    // Scoreboard countdown, lat=3: stalls exactly 3 cycles after issue
    @(negedge clk); idle(); issue(5'd9, 4'd3);
    #1;
    check("sb3_issue_stall", 32'(stall), 32'd0);
    check("sb3_issue_count", 32'(sb_count), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); idle();
      ex_valid = 1'b1; set_src(0, 5'd9);
      #1;
      check($sformatf("sb3_c%0d_stall", c), 32'(stall), (c < 3) ? 32'd1 : 32'd0);
      check($sformatf("sb3_c%0d_count", c), 32'(sb_count), (c < 3) ? 32'd1 : 32'd0);
    end

    // lat_cycles=0 behaves as 1
    @(negedge clk); idle(); issue(5'd9, 4'd0);
    #1;
    check("sb0_issue_stall", 32'(stall), 32'd0);
    @(negedge clk); idle(); ex_valid = 1'b1; set_src(0, 5'd9);
    #1;
    check("sb0_c0_stall", 32'(stall), 32'd1);
    check("sb0_c0_count", 32'(sb_count), 32'd1);
    @(negedge clk);
    #1;
    check("sb0_c1_stall", 32'(stall), 32'd0);
    check("sb0_c1_count", 32'(sb_count), 32'd0);

    // rd=x0 never allocates
    @(negedge clk); idle(); issue(5'd0, 4'd5);
    #1;
    check("rd0_stall", 32'(stall), 32'd0);
    @(negedge clk); idle();
    #1;
    check("rd0_count", 32'(sb_count), 32'd0);

    // Fill all four entries, then a fifth issue stalls
    for (int r = 10; r < 14; r++) begin
      @(negedge clk); idle(); issue(5'(r), 4'd8);
      #1;
      check($sformatf("fill_x%0d_stall", r), 32'(stall), 32'd0);
    end
    @(negedge clk); idle(); issue(5'd14, 4'd8);
    #1;
    check("full_count", 32'(sb_count), 32'd4);
    check("full_flag", 32'(sb_full), 32'd1);
    check("full_issue_stall", 32'(stall), 32'd1);
    @(negedge clk); idle(); flush = 1'b1;
    #1;
    check("full_no_alloc_count", 32'(sb_count), 32'd4);
    @(negedge clk); idle();
    #1;
    check("full_flushed_count", 32'(sb_count), 32'd0);
    check("full_flushed_flag", 32'(sb_full), 32'd0);

    // WAW with free slots
    @(negedge clk); idle(); issue(5'd11, 4'd8);
    #1;
    check("waw_first_stall", 32'(stall), 32'd0);
    @(negedge clk); idle(); issue(5'd11, 4'd8);
    #1;
    check("waw_stall", 32'(stall), 32'd1);
    check("waw_full", 32'(sb_full), 32'd0);
    @(negedge clk); idle(); issue(5'd12, 4'd8);
    #1;
    check("waw_no_alloc_count", 32'(sb_count), 32'd1);
    check("waw_other_stall", 32'(stall), 32'd0);
    @(negedge clk); idle(); flush = 1'b1;
    #1;
    check("waw_two_count", 32'(sb_count), 32'd2);

    // Flush with three pending beats a simultaneous allocation
    for (int r = 20; r < 23; r++) begin
      @(negedge clk); idle(); issue(5'(r), 4'd8);
      #1;
    end
    @(negedge clk); idle(); issue(5'd23, 4'd8); flush = 1'b1;
    #1;
    check("flush_pre_count", 32'(sb_count), 32'd3);
    check("flush_issue_stall", 32'(stall), 32'd0);
    @(negedge clk); idle();
    #1;
    check("flush_post_count", 32'(sb_count), 32'd0);

    // Reset mid-countdown
    @(negedge clk); idle(); issue(5'd9, 4'd8);
    #1;
    @(negedge clk); idle();
    ex_valid = 1'b1; set_src(0, 5'd9); set_fwd(0, 1'b1, 5'd9, 1'b1);
    #1;
    check("rstmid_pre_stall", 32'(stall), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstmid_stall", 32'(stall), 32'd0);
    check("rstmid_sel", 32'(fwd_sel), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rstmid_post_stall", 32'(stall), 32'd0);
    check("rstmid_post_count", 32'(sb_count), 32'd0);
    check("rstmid_post_sel", sel_of(0), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/operand_bypass_ctrl.md
Name: operand_bypass_ctrl

Overview:
Parametrised successor to the core's two-stage, two-operand forwarding logic. Selects bypass sources for up to NUM_SRC EX operands from NUM_FWD later stages. Detects load-use hazards and tracks in-flight long-latency writes (div, vector) in a countdown scoreboard. Drives the EX operand muxes and the pipeline stall line.

Parameters:
NUM_SRC, 3, EX source operands (rs1, rs2, rs3/vector source)
NUM_FWD, 2, forwarding stages; index 0 = youngest (MEM), NUM_FWD-1 = oldest (WB)
ADDR_W, 5, register address width
NUM_SB, 4, scoreboard entries for long-latency ops
MAX_LAT, 15, maximum long-latency cycles; CNT_W = $clog2(MAX_LAT+1)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX holds a valid instruction
ex_src_addr  in  NUM_SRC*ADDR_W  source register addresses, src i at [i*ADDR_W +: ADDR_W]
ex_src_used  in  NUM_SRC  operand i is actually read
fwd_reg_write  in  NUM_FWD  stage k will write rd
fwd_rd_addr  in  NUM_FWD*ADDR_W  stage k destination
fwd_data_ready  in  NUM_FWD  stage k result is already valid (0 for a load in MEM)
lat_issue  in  1  EX instruction is long-latency
lat_rd_addr  in  ADDR_W  its destination
lat_cycles  in  CNT_W  cycles until its result reaches the register file
flush  in  1  pipeline flush; kills all pending scoreboard entries
fwd_sel  out  NUM_SRC*SEL_W  per-operand mux select, SEL_W=$clog2(NUM_FWD+1); 0 = register file, k+1 = stage k
stall  out  1  hold IF/ID/EX, insert bubble
sb_full  out  1  no free scoreboard entry
sb_count  out  $clog2(NUM_SB+1)  valid entries

Behaviour:
- Reset (rst=1 at clk edge): all scoreboard entries invalid, sb_count=0, sb_full=0. While rst is high, stall=0 and fwd_sel=0 (forced combinationally).
- fwd_sel (combinational, 0-cycle latency), per operand i:
  - Forced to 0 if !ex_src_used[i] or addr==0.
  - Otherwise the youngest k with fwd_reg_write[k] && fwd_rd_addr[k]==addr gives sel=k+1; no match gives 0.
  - Priority is strictly youngest-first; matches in older stages are ignored once a younger stage matches.
- stall (combinational) = ex_valid && (H_load || H_sb || H_issue):
  - H_load: any used, nonzero operand whose youngest matching stage k has fwd_data_ready[k]=0.
  - H_sb: any used, nonzero operand matching a valid scoreboard rd.
  - H_issue: lat_issue && (sb_full || lat_rd_addr matches a valid entry (WAW)).
- Scoreboard entry fields: valid, rd, cnt[CNT_W].
- Allocation: on ex_valid && lat_issue && !stall && !flush && lat_rd_addr!=0, the lowest-index free entry gets valid=1, rd=lat_rd_addr, cnt=max(lat_cycles,1). Effective next cycle.
- Countdown: every cycle each valid entry decrements cnt. An entry with cnt==1 clears valid at that edge, so it stops stalling the following cycle (the result is then visible via the normal forwarding stages).
- Simultaneous retire and allocate: the freed slot may not be reused the same cycle. sb_full is computed from current state.
- flush: all entries invalidate at the next edge. flush takes precedence over allocation and countdown.
- lat_rd_addr==0 never allocates.
- lat_cycles>MAX_LAT is unrepresentable by width; no saturation logic needed.
- sb_count and sb_full are registered-state derived (popcount of valid), with no combinational path from inputs.

Optional Feature:
- Macro BYPASS_PERF_CNT_EN.
- When defined, adds outputs perf_stall_load, perf_stall_sb and perf_fwd_hits, each 32 bits, synchronous-reset to 0.
  - perf_stall_load and perf_stall_sb increment once per cycle in which stall=1 with the respective cause. If both causes are present, both increment.
  - perf_fwd_hits adds the number of operands with fwd_sel!=0 when ex_valid && !stall.
  - All counters wrap at 2^32.
- When undefined, these ports and registers do not exist and the behaviour above is unchanged.

Test Plan:
- Forwarding priority: src0=x5; stage0 writes x5 (ready), stage1 writes x5 -> fwd_sel[0]=1, stall=0. Clear stage0 write -> fwd_sel[0]=2.
- x0 and unused operands: src1=x0 with stage0 writing x0; src2=x7 with ex_src_used[2]=0 and stage0 writing x7 -> both sels 0, stall=0.
- Load-use: src0=x3, stage0 writes x3 with fwd_data_ready[0]=0 -> stall=1. Next cycle data_ready=1 -> stall=0, fwd_sel[0]=1.
- Scoreboard countdown: issue x9 with lat_cycles=3. Then src0=x9 -> stall=1 for exactly 3 cycles following the issue cycle, sb_count 1 -> 0. lat_cycles=0 behaves as 1.
- Full and WAW: fill 4 entries (x10..x13, lat=8) -> sb_full=1, and a 5th issue stalls. An issue to x11 while it is pending stalls even with a free slot.
- Flush and reset mid-operation: with 3 entries pending, assert flush -> sb_count=0 next cycle, no allocation that cycle. Assert rst mid-countdown -> stall=0, fwd_sel=0 during reset, all entries cleared.
